// File: rtl/apb_reg_bridge_pkg.sv
// Shared types and constants for the APB to register-port bridge.
package apb_reg_bridge_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} bridge_state_t;

  localparam int unsigned WORD_LSB = 2;

endpackage

// File: rtl/apb_reg_bridge.sv
// APB3 completer driving a single-cycle cs/we register port with a fixed response latency.
// Alignment and range are checked at setup; bad addresses complete immediately with an error.
module apb_reg_bridge
  import apb_reg_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned PADDR_WIDTH   = 12,
  parameter int unsigned RESP_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [PADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]    pwdata,
  output logic                     pready,
  output logic [DATA_WIDTH-1:0]    prdata,
  output logic                     pslverr,
  output logic                     reg_cs,
  output logic                     reg_we,
  output logic [ADDRESS_WIDTH-1:0] reg_address,
  output logic [DATA_WIDTH-1:0]    reg_write_data,
  input  logic [DATA_WIDTH-1:0]    reg_read_data,
  input  logic                     reg_error
);

  localparam int unsigned CNT_W = $clog2(RESP_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESP_LATENCY - 1);

  bridge_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic             write_q;
  logic             aborted;
  logic             hi_bad;
  logic             addr_bad;

  // When the APB space exactly matches the register space there are no upper bits to check.
  if (PADDR_WIDTH > ADDRESS_WIDTH + WORD_LSB) begin : g_hi_chk
    assign hi_bad = |paddr[PADDR_WIDTH-1:ADDRESS_WIDTH+WORD_LSB];
  end else begin : g_no_hi_chk
    assign hi_bad = 1'b0;
  end

  assign addr_bad = (|paddr[WORD_LSB-1:0]) | hi_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      write_q        <= 1'b0;
      aborted        <= 1'b0;
      pready         <= 1'b0;
      prdata         <= '0;
      pslverr        <= 1'b0;
      reg_cs         <= 1'b0;
      reg_we         <= 1'b0;
      reg_address    <= '0;
      reg_write_data <= '0;
    end else begin
      reg_cs <= 1'b0;
      reg_we <= 1'b0;
      pready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (psel && !penable) begin
            write_q        <= pwrite;
            aborted        <= 1'b0;
            reg_address    <= paddr[ADDRESS_WIDTH+WORD_LSB-1:WORD_LSB];
            reg_write_data <= pwdata;
            if (addr_bad) begin
              state   <= RESP;
              pready  <= 1'b1;
              pslverr <= 1'b1;
            end else begin
              state  <= ISSUE;
              reg_cs <= 1'b1;
              reg_we <= pwrite;
            end
          end
        end
        ISSUE: begin
          cnt   <= CNT_LOAD;
          state <= WAIT;
          if (!psel) aborted <= 1'b1;
        end
        WAIT: begin
          if (cnt == '0) begin
            // The downstream access has finished; an abandoned transfer just returns to idle.
            if (aborted || !psel) begin
              state <= IDLE;
            end else begin
              state   <= RESP;
              pready  <= 1'b1;
              pslverr <= reg_error;
              prdata  <= (!write_q && !reg_error) ? reg_read_data : '0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (!psel) aborted <= 1'b1;
          end
        end
        RESP: begin
          state   <= IDLE;
          pslverr <= 1'b0;
          prdata  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Scoreboard bench for apb_reg_bridge: two instances (latency 1 and 3) with a simple register model.
module tb_apb_reg_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [11:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic        pready  [2];
  logic [31:0] prdata  [2];
  logic        pslverr [2];
  logic        reg_cs  [2];
  logic        reg_we  [2];
  logic [7:0]  reg_address    [2];
  logic [31:0] reg_write_data [2];
  logic [31:0] reg_read_data  [2];
  logic        reg_error      [2];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    int          idx;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          cyc;
  } cs_t;

  rsp_t rsp_q[$];
  cs_t  cs_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_reg_bridge #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(8), .PADDR_WIDTH(12), .RESP_LATENCY(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .pready(pready[0]), .prdata(prdata[0]),
    .pslverr(pslverr[0]), .reg_cs(reg_cs[0]), .reg_we(reg_we[0]),
    .reg_address(reg_address[0]), .reg_write_data(reg_write_data[0]),
    .reg_read_data(reg_read_data[0]), .reg_error(reg_error[0])
  );

  apb_reg_bridge #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(8), .PADDR_WIDTH(12), .RESP_LATENCY(3)
  ) u_dut3 (
    .clk(clk), .reset(reset), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .pready(pready[1]), .prdata(prdata[1]),
    .pslverr(pslverr[1]), .reg_cs(reg_cs[1]), .reg_we(reg_we[1]),
    .reg_address(reg_address[1]), .reg_write_data(reg_write_data[1]),
    .reg_read_data(reg_read_data[1]), .reg_error(reg_error[1])
  );

  // Register model: word memory, error flagged for word address 0x20, data valid L cycles after cs.
  logic [31:0] mem [256];

  always @(posedge clk) begin
    if (reset) begin
      mem[8'hFF] <= 32'h12345678;
      mem[8'h20] <= 32'hAAAA5555;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (reg_cs[g] && reg_we[g]) mem[reg_address[g]] <= reg_write_data[g];
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam int L = (g == 0) ? 1 : 3;
    logic [7:0] pipe [L];
    always @(posedge clk) begin
      if (reg_cs[g]) pipe[0] <= reg_address[g];
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign reg_read_data[g] = mem[pipe[L-1]];
    assign reg_error[g]     = (pipe[L-1] == 8'h20);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the matching expectation whenever a DUT presents pready or reg_cs.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        int f;
        if (pready[i]) begin
          f = -1;
          for (int k = 0; k < rsp_q.size(); k++) if (f < 0 && rsp_q[k].idx == i) f = k;
          if (f < 0) flag($sformatf("unexpected_pready dut%0d", i));
          else begin
            check($sformatf("prdata dut%0d", i), prdata[i], rsp_q[f].rdata);
            check($sformatf("pslverr dut%0d", i), pslverr[i], rsp_q[f].err);
            check($sformatf("pready_cycle dut%0d", i), cyc, rsp_q[f].cyc);
            rsp_q.delete(f);
          end
        end
        if (reg_cs[i]) begin
          f = -1;
          for (int k = 0; k < cs_q.size(); k++) if (f < 0 && cs_q[k].idx == i) f = k;
          if (f < 0) flag($sformatf("unexpected_reg_cs dut%0d", i));
          else begin
            check($sformatf("reg_we dut%0d", i), reg_we[i], cs_q[f].we);
            check($sformatf("reg_address dut%0d", i), reg_address[i], cs_q[f].addr);
            check($sformatf("reg_write_data dut%0d", i), reg_write_data[i], cs_q[f].wdata);
            check($sformatf("reg_cs_cycle dut%0d", i), cyc, cs_q[f].cyc);
            cs_q.delete(f);
          end
        end
      end
    end
  end

  // Setup phase starts in the current cycle (called #1 after a posedge).
  task automatic start(input int i, input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic bad, output int c0);
    c0 = cyc;
    if (!bad) cs_q.push_back('{idx: i, we: w, addr: a[9:2], wdata: d, cyc: c0 + 1});
    psel[i]    = 1'b1;
    penable[i] = 1'b0;
    pwrite[i]  = w;
    paddr[i]   = a;
    pwdata[i]  = d;
    @(posedge clk);
    #1 penable[i] = 1'b1;
  endtask

  task automatic xfer(input int i, input logic w, input logic [11:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input logic bad,
                      output int c0);
    int  lat;
    int  n;
    bit  done;
    lat = (i == 0) ? 1 : 3;
    rsp_q.push_back('{idx: i, rdata: exp_rd, err: exp_err, cyc: bad ? cyc + 1 : cyc + 2 + lat});
    start(i, w, a, d, bad, c0);
    done = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (pready[i]) done = 1'b1;
      n++;
    end
    if (!done) flag($sformatf("pready_timeout dut%0d addr 0x%0h", i, a));
    @(posedge clk);
    #1;
    psel[i]    = 1'b0;
    penable[i] = 1'b0;
  endtask

  task automatic idle(input int i);
    psel[i]    = 1'b0;
    penable[i] = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s pready dut%0d", tag, i), pready[i], 0);
      check($sformatf("%s prdata dut%0d", tag, i), prdata[i], 0);
      check($sformatf("%s pslverr dut%0d", tag, i), pslverr[i], 0);
      check($sformatf("%s reg_cs dut%0d", tag, i), reg_cs[i], 0);
      check($sformatf("%s reg_we dut%0d", tag, i), reg_we[i], 0);
      check($sformatf("%s reg_address dut%0d", tag, i), reg_address[i], 0);
      check($sformatf("%s reg_write_data dut%0d", tag, i), reg_write_data[i], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c_prev;
    logic [11:0] b2b_addr [4];
    logic [31:0] b2b_data [4];
    logic        b2b_err  [4];

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      idle(i);
      pwrite[i] = 1'b0;
      paddr[i]  = '0;
      pwdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic write, reads, bad addresses and downstream error on the latency-1 instance.
    xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, c0);
    xfer(0, 1'b0, 12'h3FC, 32'h0, 32'h12345678, 1'b0, 1'b0, c0);
    xfer(0, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, c0);
    xfer(0, 1'b0, 12'h011, 32'h0, 32'h0, 1'b1, 1'b1, c0);
    xfer(0, 1'b1, 12'h400, 32'h11112222, 32'h0, 1'b1, 1'b1, c0);
    xfer(0, 1'b0, 12'h080, 32'h0, 32'h0, 1'b1, 1'b0, c0);
    xfer(0, 1'b1, 12'h080, 32'h55555555, 32'h0, 1'b1, 1'b0, c0);

    // Latency-3 instance.
    xfer(1, 1'b0, 12'h3FC, 32'h0, 32'h12345678, 1'b0, 1'b0, c0);

    // Abort in WAIT: reg_cs still pulses, pready must never appear.
    start(0, 1'b0, 12'h3FC, 32'h0, 1'b0, c0);
    @(posedge clk);
    #1 idle(0);
    repeat (6) @(posedge clk);
    #1;

    // Abort in ISSUE.
    start(0, 1'b0, 12'h010, 32'h0, 1'b0, c0);
    idle(0);
    repeat (6) @(posedge clk);
    #1;

    // Back-to-back reads: each setup follows the previous one by exactly 4 cycles.
    b2b_addr = '{12'h3FC, 12'h010, 12'h080, 12'h3FC};
    b2b_data = '{32'h12345678, 32'hDEADBEEF, 32'h0, 32'h12345678};
    b2b_err  = '{1'b0, 1'b0, 1'b1, 1'b0};
    c_prev = -1;
    for (int k = 0; k < 4; k++) begin
      xfer(0, 1'b0, b2b_addr[k], 32'h0, b2b_data[k], b2b_err[k], 1'b0, c0);
      if (c_prev >= 0) check($sformatf("b2b_spacing %0d", k), c0 - c_prev, 4);
      c_prev = c0;
    end

    // Reset during WAIT clears everything at once; the next transfer is normal.
    start(0, 1'b0, 12'h3FC, 32'h0, 1'b0, c0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check_zero("mid_reset");
    idle(0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    xfer(0, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, c0);

    repeat (6) @(posedge clk);
    #1;
    check("rsp_queue_empty", rsp_q.size(), 0);
    check("cs_queue_empty", cs_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
